// File: rtl/usb_pd_prl_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_pd_prl_rx_if : PHY, TCPM and RX-buffer signals of the PD RX path |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface usb_pd_prl_rx_if;
  logic         PHY_RX_VALID;
  logic [2:0]   PHY_RX_FRAME_TYPE;
  logic [15:0]  PHY_RX_HEADER;
  logic [7:0]   PHY_RX_BYTE_COUNT;
  logic [223:0] PHY_RX_DATA;
  logic [7:0]   RECEIVE_DETECT;
  logic [15:0]  GOODCRC_HEADER_TEMPLATE;
  logic         GoodCRC_Transmit_Complete;
  logic         ALERT_CLEAR;

  logic         GoodCRC_Request;
  logic [15:0]  GoodCRC_HEADER;
  logic [7:0]   RX_BUF_FRAME_TYPE;
  logic [7:0]   RX_BUF_HEADER_BYTE_0;
  logic [7:0]   RX_BUF_HEADER_BYTE_1;
  logic [7:0]   RX_BUF_BYTE_COUNT;
  logic [223:0] RX_BUF_DATA_OBJECTS;
  logic         ALERT_ReceiveSOP_MessageStatus;
  logic         GoodCRC_Response;
  logic         ALERT_ReceivedHardReset;
  logic         PRL_Rx_Soft_Reset;

  modport master (
    output PHY_RX_VALID, PHY_RX_FRAME_TYPE, PHY_RX_HEADER, PHY_RX_BYTE_COUNT,
           PHY_RX_DATA, RECEIVE_DETECT, GOODCRC_HEADER_TEMPLATE,
           GoodCRC_Transmit_Complete, ALERT_CLEAR,
    input  GoodCRC_Request, GoodCRC_HEADER, RX_BUF_FRAME_TYPE,
           RX_BUF_HEADER_BYTE_0, RX_BUF_HEADER_BYTE_1, RX_BUF_BYTE_COUNT,
           RX_BUF_DATA_OBJECTS, ALERT_ReceiveSOP_MessageStatus,
           GoodCRC_Response, ALERT_ReceivedHardReset, PRL_Rx_Soft_Reset
  );

  modport slave (
    input  PHY_RX_VALID, PHY_RX_FRAME_TYPE, PHY_RX_HEADER, PHY_RX_BYTE_COUNT,
           PHY_RX_DATA, RECEIVE_DETECT, GOODCRC_HEADER_TEMPLATE,
           GoodCRC_Transmit_Complete, ALERT_CLEAR,
    output GoodCRC_Request, GoodCRC_HEADER, RX_BUF_FRAME_TYPE,
           RX_BUF_HEADER_BYTE_0, RX_BUF_HEADER_BYTE_1, RX_BUF_BYTE_COUNT,
           RX_BUF_DATA_OBJECTS, ALERT_ReceiveSOP_MessageStatus,
           GoodCRC_Response, ALERT_ReceivedHardReset, PRL_Rx_Soft_Reset
  );
endinterface
`default_nettype wire

// File: rtl/usb_pd_prl_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | usb_pd_prl_rx : USB PD protocol-layer receive FSM (GoodCRC, dedup)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module usb_pd_prl_rx #(
  parameter int GOODCRC_TIMEOUT = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  usb_pd_prl_rx_if.slave bus
);

  localparam int CNT_W = (GOODCRC_TIMEOUT > 1) ? $clog2(GOODCRC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(GOODCRC_TIMEOUT - 1);
  localparam logic [2:0]       FT_HARD_RESET = 3'd5;
  localparam logic [2:0]       FT_MAX        = 3'd6;
  localparam logic [4:0]       MT_GOODCRC    = 5'h01;
  localparam logic [4:0]       MT_SOFT_RESET = 5'h0D;

  typedef enum logic [1:0] {
    WAIT_FOR_PHY_MESSAGE = 2'd0,
    SEND_GOODCRC         = 2'd1,
    CHECK_MESSAGEID      = 2'd2,
    STORE_MESSAGE        = 2'd3
  } state_t;

  state_t state, state_next;

  logic [2:0]       cap_frame;
  logic [15:0]      cap_header;
  logic [7:0]       cap_byte_count;
  logic [223:0]     cap_data;
  logic [CNT_W-1:0] crc_cnt;
  logic [2:0]       stored_id [5];
  logic [4:0]       id_valid;

  logic [7:0]       buf_frame_type;
  logic [15:0]      buf_header;
  logic [7:0]       buf_byte_count;
  logic [223:0]     buf_data;
  logic             alert;
  logic             goodcrc_response;
  logic             hard_reset_pulse;
  logic             soft_reset_pulse;

  logic             accept;
  logic             goodcrc_rx;
  logic             store;

  logic [2:0] rx_frame;
  logic       rx_enabled;
  logic       rx_hard_reset;
  logic       rx_sop;
  logic       rx_goodcrc;
  logic [2:0] cap_id;
  logic       cap_soft_reset;
  logic       cap_duplicate;

  assign rx_frame      = bus.PHY_RX_FRAME_TYPE;
  assign rx_enabled    = bus.PHY_RX_VALID && (rx_frame <= FT_MAX) && bus.RECEIVE_DETECT[rx_frame];
  assign rx_hard_reset = rx_enabled && (rx_frame == FT_HARD_RESET);
  assign rx_sop        = rx_enabled && (rx_frame < FT_HARD_RESET);
  assign rx_goodcrc    = (bus.PHY_RX_HEADER[4:0] == MT_GOODCRC) && (bus.PHY_RX_HEADER[14:12] == 3'd0);

  assign cap_id         = cap_header[11:9];
  assign cap_soft_reset = (cap_header[4:0] == MT_SOFT_RESET) && (cap_header[14:12] == 3'd0);
  // Soft_Reset restarts the ID sequence, so it is never treated as a retry.
  assign cap_duplicate  = !cap_soft_reset && id_valid[cap_frame] && (stored_id[cap_frame] == cap_id);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    goodcrc_rx = 1'b0;
    store      = 1'b0;
    case (state)
      WAIT_FOR_PHY_MESSAGE: begin
        if (rx_sop) begin
          if (rx_goodcrc) begin
            goodcrc_rx = 1'b1;
          end else if (!alert) begin
            accept     = 1'b1;
            state_next = SEND_GOODCRC;
          end
        end
      end
      SEND_GOODCRC: begin
        if (bus.GoodCRC_Transmit_Complete) begin
          state_next = CHECK_MESSAGEID;
        end else if (crc_cnt == CNT_LAST) begin
          state_next = WAIT_FOR_PHY_MESSAGE;
        end
      end
      CHECK_MESSAGEID: begin
        state_next = cap_duplicate ? WAIT_FOR_PHY_MESSAGE : STORE_MESSAGE;
      end
      STORE_MESSAGE: begin
        store      = 1'b1;
        state_next = WAIT_FOR_PHY_MESSAGE;
      end
      default: state_next = WAIT_FOR_PHY_MESSAGE;
    endcase
    // Hard Reset pre-empts whatever message is in flight.
    if (rx_hard_reset) begin
      state_next = WAIT_FOR_PHY_MESSAGE;
      accept     = 1'b0;
      store      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= WAIT_FOR_PHY_MESSAGE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cap_frame        <= '0;
      cap_header       <= '0;
      cap_byte_count   <= '0;
      cap_data         <= '0;
      crc_cnt          <= '0;
      id_valid         <= '0;
      for (int i = 0; i < 5; i++) begin
        stored_id[i] <= '0;
      end
      buf_frame_type   <= '0;
      buf_header       <= '0;
      buf_byte_count   <= '0;
      buf_data         <= '0;
      alert            <= 1'b0;
      goodcrc_response <= 1'b0;
      hard_reset_pulse <= 1'b0;
      soft_reset_pulse <= 1'b0;
    end else begin
      goodcrc_response <= 1'b0;
      hard_reset_pulse <= 1'b0;
      soft_reset_pulse <= 1'b0;

      if (accept) begin
        cap_frame      <= rx_frame;
        cap_header     <= bus.PHY_RX_HEADER;
        cap_byte_count <= bus.PHY_RX_BYTE_COUNT;
        cap_data       <= bus.PHY_RX_DATA;
      end

      crc_cnt <= (state == SEND_GOODCRC) ? crc_cnt + 1'b1 : '0;

      if (goodcrc_rx) begin
        buf_frame_type   <= {5'd0, rx_frame};
        buf_header       <= bus.PHY_RX_HEADER;
        goodcrc_response <= 1'b1;
      end

      if (rx_hard_reset) begin
        hard_reset_pulse <= 1'b1;
        id_valid         <= '0;
      end

      if (bus.ALERT_CLEAR) begin
        alert <= 1'b0;
      end

      // Placed after the clear so a same-cycle store keeps the alert set.
      if (store) begin
        buf_frame_type       <= {5'd0, cap_frame};
        buf_header           <= cap_header;
        buf_byte_count       <= cap_byte_count;
        buf_data             <= cap_data;
        alert                <= 1'b1;
        stored_id[cap_frame] <= cap_id;
        if (cap_soft_reset) begin
          id_valid         <= '0;
          soft_reset_pulse <= 1'b1;
        end
        id_valid[cap_frame] <= 1'b1;
      end
    end
  end

  assign bus.GoodCRC_Request = (state == SEND_GOODCRC);
  assign bus.GoodCRC_HEADER  = (state == SEND_GOODCRC) ?
      {bus.GOODCRC_HEADER_TEMPLATE[15], 3'd0, cap_id, bus.GOODCRC_HEADER_TEMPLATE[8:5], MT_GOODCRC} :
      16'd0;

  assign bus.RX_BUF_FRAME_TYPE              = buf_frame_type;
  assign bus.RX_BUF_HEADER_BYTE_0           = buf_header[7:0];
  assign bus.RX_BUF_HEADER_BYTE_1           = buf_header[15:8];
  assign bus.RX_BUF_BYTE_COUNT              = buf_byte_count;
  assign bus.RX_BUF_DATA_OBJECTS            = buf_data;
  assign bus.ALERT_ReceiveSOP_MessageStatus = alert;
  assign bus.GoodCRC_Response               = goodcrc_response;
  assign bus.ALERT_ReceivedHardReset        = hard_reset_pulse;
  assign bus.PRL_Rx_Soft_Reset              = soft_reset_pulse;

endmodule
`default_nettype wire

// File: doc/usb_pd_prl_rx.md
# usb_pd_prl_rx

Protocol-layer receive state machine for the USB PD port, the counterpart of the protocol-layer transmitter.
- Accepts one decoded message per PHY strobe and filters it by SOP type and receive-buffer state.
- Requests a GoodCRC reply from the PHY, discards retried duplicates by per-SOP MessageID, and stores new messages into the RX buffer registers with an alert to the TCPM.
- Forwards incoming GoodCRC messages to the transmitter and handles Hard Reset / Soft Reset reception.

## Interface
Parameters:
- GOODCRC_TIMEOUT, 8: cycles allowed in SEND_GOODCRC for the PHY to finish the GoodCRC before the message is dropped.

Ports (name, direction, width, meaning):
- CLK, in, 1: clock; all logic is on the rising edge.
- RESET, in, 1: synchronous, active-high reset.
- PHY_RX_VALID, in, 1: one-cycle strobe; the PHY_RX_* fields are valid in this cycle.
- PHY_RX_FRAME_TYPE, in, 3: frame type code (0 SOP, 1 SOP', 2 SOP'', 3 SOP_DBG', 4 SOP_DBG'', 5 Hard Reset, 6 Cable Reset).
- PHY_RX_HEADER, in, 16: message header. MessageID is [11:9], NumDataObjects is [14:12], MessageType is [4:0].
- PHY_RX_BYTE_COUNT, in, 8: byte count including the header.
- PHY_RX_DATA, in, 224: data objects.
- RECEIVE_DETECT, in, 8: enable per frame type; bit n enables code n.
- GOODCRC_HEADER_TEMPLATE, in, 16: role and revision bits used for the GoodCRC header.
- GoodCRC_Transmit_Complete, in, 1: PHY finished sending the GoodCRC.
- ALERT_CLEAR, in, 1: TCPM has read the buffer; clears ALERT_ReceiveSOP_MessageStatus.
- GoodCRC_Request, out, 1: level signal; asks the PHY to send a GoodCRC.
- GoodCRC_HEADER, out, 16: header for the GoodCRC.
- RX_BUF_FRAME_TYPE, out, 8: stored frame type, zero-extended.
- RX_BUF_HEADER_BYTE_0, out, 8: stored header low byte.
- RX_BUF_HEADER_BYTE_1, out, 8: stored header high byte.
- RX_BUF_BYTE_COUNT, out, 8: stored byte count.
- RX_BUF_DATA_OBJECTS, out, 224: stored data objects.
- ALERT_ReceiveSOP_MessageStatus, out, 1: RX buffer holds an unread message.
- GoodCRC_Response, out, 1: one-cycle pulse when a GoodCRC is received.
- ALERT_ReceivedHardReset, out, 1: one-cycle pulse when a Hard Reset is received.
- PRL_Rx_Soft_Reset, out, 1: one-cycle pulse when an accepted Soft_Reset is stored.

## Operation
Reset:
- All outputs are 0.
- The five StoredMessageID[2:0] values are cleared and their valid flags are cleared.
- The state goes to WAIT_FOR_PHY_MESSAGE.
- A RESET during any state aborts the message: no ID update and no alert.

States:
- WAIT_FOR_PHY_MESSAGE: captures the PHY_RX_* fields on PHY_RX_VALID and checks them in this order:
  - Frame type above 6, or RECEIVE_DETECT bit clear: ignore.
  - Frame type 5: pulse ALERT_ReceivedHardReset, invalidate all stored IDs, stay in this state.
  - Frame type 6: ignore.
  - GoodCRC message (MessageType 1, NumDataObjects 0): write the RX_BUF_FRAME_TYPE and header byte outputs, pulse GoodCRC_Response, no alert, no GoodCRC reply.
  - ALERT_ReceiveSOP_MessageStatus is 1 (buffer full): drop the message silently, no GoodCRC.
  - Otherwise: go to SEND_GOODCRC.
- SEND_GOODCRC:
  - GoodCRC_Request is 1.
  - GoodCRC_HEADER is the template with [4:0] = 1, [14:12] = 0 and [11:9] = the captured MessageID.
  - A cycle counter starts at 0.
  - On GoodCRC_Transmit_Complete, go to CHECK_MESSAGEID.
  - If the counter reaches GOODCRC_TIMEOUT-1 without completion, drop the message and go to WAIT_FOR_PHY_MESSAGE.
- CHECK_MESSAGEID:
  - A Soft_Reset (MessageType 0x0D, NumDataObjects 0) always passes.
  - Any other message is a duplicate if the valid flag is set and StoredMessageID equals the captured MessageID for its frame type. Duplicates go to WAIT_FOR_PHY_MESSAGE with no store.
  - Otherwise go to STORE_MESSAGE.
- STORE_MESSAGE:
  - Writes all RX_BUF_* outputs, sets ALERT_ReceiveSOP_MessageStatus, stores the MessageID and sets its valid flag.
  - For a Soft_Reset, invalidates the stored IDs of all other frame types and pulses PRL_Rx_Soft_Reset.
  - Goes to WAIT_FOR_PHY_MESSAGE.

Other rules:
- PHY_RX_VALID outside WAIT_FOR_PHY_MESSAGE is ignored; exception: a Hard Reset is always processed. It aborts the current message, drops GoodCRC_Request and returns to WAIT_FOR_PHY_MESSAGE.
- ALERT_CLEAR clears the alert on the next edge. If ALERT_CLEAR and the STORE_MESSAGE set happen in the same cycle, the set wins.
- The buffer-full check is made only at capture. A clear that arrives later does not revive a dropped message.

## Timing
- PHY_RX_VALID in cycle N gives GoodCRC_Request = 1 from cycle N+1.
- GoodCRC_Transmit_Complete in cycle M drops GoodCRC_Request in M+1 (CHECK_MESSAGEID) and raises RX_BUF_* and the alert in M+3.
- GoodCRC_Response and ALERT_ReceivedHardReset go high in N+1 and last exactly one cycle.
- Completion asserted in the same cycle the timeout is reached counts as success.
- MessageID comparison is exact over 3 bits; ID 0 following ID 7 is a new message.

## Test plan
- SOP message with ID 3 and 2 data objects, Complete 2 cycles after the request → GoodCRC_HEADER[11:9] = 3, alert = 1, RX_BUF_BYTE_COUNT = 10, RX_BUF_HEADER_BYTE_1 = header[15:8].
- Same message resent after ALERT_CLEAR → GoodCRC is requested, no store, alert stays 0.
- Second message arriving while the alert is 1 → no GoodCRC_Request and the buffer is unchanged. After ALERT_CLEAR, ID 4 is accepted.
- Complete never asserted, GOODCRC_TIMEOUT = 8 → request is high for exactly 8 cycles, no store, then the same ID is accepted on retry.
- Hard Reset during SEND_GOODCRC → ALERT_ReceivedHardReset pulses, request drops next cycle, a following ID 3 is accepted as new.
- Soft_Reset with ID 0 after SOP ID 0 was stored → stored despite the matching ID, PRL_Rx_Soft_Reset pulses. An incoming GoodCRC → GoodCRC_Response pulse, no alert.
